// File: rtl/vga_tx.sv
// VGA timing generator: divides the 50 MHz clock to a pixel tick, walks the
// raster counters and registers colour/sync/status one tick behind the counters.
module vga_tx #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        I_50MHZ_CLK,
    input  logic        I_RESET,
    input  logic [2:0]  I_PIXEL_RGB,
    output logic [9:0]  O_PIXEL_X,
    output logic [9:0]  O_PIXEL_Y,
    output logic        O_RED,
    output logic        O_GREEN,
    output logic        O_BLUE,
    output logic        O_HSYNC,
    output logic        O_VSYNC,
    output logic        display_data,
    output logic        draw_finish,
    output logic        vga_25clk,
    output logic [15:0] O_FRAME_CNT
);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_FIN    = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        clk25_q, clk25_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        disp_q, disp_d, fin_q, fin_d;
    logic [15:0] frame_q, frame_d;
    logic        visible, at_finish;

    assign visible   = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign at_finish = (hcnt_q == H_VIS) && (vcnt_q == V_FIN);

    // A tick is the edge where the divided clock is high before the edge, so
    // everything below samples the counters as they were before stepping.
    always_comb begin
        clk25_d = ~clk25_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        disp_d  = disp_q;
        fin_d   = fin_q;
        frame_d = frame_q;
        if (clk25_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            disp_d  = visible;
            red_d   = visible & I_PIXEL_RGB[2];
            green_d = visible & I_PIXEL_RGB[1];
            blue_d  = visible & I_PIXEL_RGB[0];
            hsync_d = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
            vsync_d = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
            fin_d   = at_finish;
            if (at_finish) frame_d = frame_q + 16'd1;
        end
    end

    always_ff @(posedge I_50MHZ_CLK) begin
        if (I_RESET) begin
            clk25_q <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            red_q   <= 1'b0;
            green_q <= 1'b0;
            blue_q  <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            disp_q  <= 1'b0;
            fin_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            clk25_q <= clk25_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            disp_q  <= disp_d;
            fin_q   <= fin_d;
            frame_q <= frame_d;
        end
    end

    assign O_PIXEL_X    = hcnt_q;
    assign O_PIXEL_Y    = vcnt_q;
    assign O_RED        = red_q;
    assign O_GREEN      = green_q;
    assign O_BLUE       = blue_q;
    assign O_HSYNC      = hsync_q;
    assign O_VSYNC      = vsync_q;
    assign display_data = disp_q;
    assign draw_finish  = fin_q;
    assign vga_25clk    = clk25_q;
    assign O_FRAME_CNT  = frame_q;
endmodule

// File: tb/tb_vga_tx.sv
// Scoreboard bench for vga_tx on a shrunken raster: expected per-tick outputs
// are queued in raster order, a monitor pops one per pixel tick and compares.
module tb_vga_tx;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = 2 * HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rgb;
    logic [9:0]  px, py;
    logic        o_r, o_g, o_b, o_hs, o_vs, disp, fin, clk25;
    logic [15:0] fcnt;

    typedef struct packed {
        logic        vis, r, g, b, hs, vs, df;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   df_total = 0;
    int   vis_cnt = 0;
    int   cyc = 0;
    int   last_df = -1;

    vga_tx #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .I_50MHZ_CLK(clk), .I_RESET(rst), .I_PIXEL_RGB(rgb),
        .O_PIXEL_X(px), .O_PIXEL_Y(py),
        .O_RED(o_r), .O_GREEN(o_g), .O_BLUE(o_b),
        .O_HSYNC(o_hs), .O_VSYNC(o_vs),
        .display_data(disp), .draw_finish(fin), .vga_25clk(clk25),
        .O_FRAME_CNT(fcnt)
    );

    always #5 clk = ~clk;

    // Pixel source: colour pattern derived from the requested coordinate.
    always_comb rgb = {px[0], py[0], px[1]};

    task automatic push_frames(input int n);
        exp_t        e;
        logic [15:0] fc;
        logic [9:0]  xv, yv;
        fc = 16'd0;
        for (int f = 0; f < n; f++)
            for (int y = 0; y < VT; y++)
                for (int x = 0; x < HT; x++) begin
                    xv    = 10'(x);
                    yv    = 10'(y);
                    e.vis = (x < HV) && (y < VV);
                    e.r   = e.vis & xv[0];
                    e.g   = e.vis & yv[0];
                    e.b   = e.vis & xv[1];
                    e.hs  = !((x >= HV + HF) && (x < HV + HF + HS));
                    e.vs  = !((y >= VV + VF) && (y < VV + VF + VS));
                    e.df  = (x == HV) && (y == VV - 1);
                    if (e.df) fc = fc + 16'd1;
                    e.fc  = fc;
                    q.push_back(e);
                end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " vga_25clk"}, int'(clk25), 0);
        chk({tag, " pixel_x"}, int'(px), 0);
        chk({tag, " pixel_y"}, int'(py), 0);
        chk({tag, " rgb"}, int'({o_r, o_g, o_b}), 0);
        chk({tag, " display_data"}, int'(disp), 0);
        chk({tag, " draw_finish"}, int'(fin), 0);
        chk({tag, " hsync"}, int'(o_hs), 1);
        chk({tag, " vsync"}, int'(o_vs), 1);
        chk({tag, " frame_cnt"}, int'(fcnt), 0);
    endtask

    // Monitor: a tick is an edge with the divided clock high and reset low
    // beforehand; outputs are sampled 1 time unit after that edge.
    always @(posedge clk) begin : mon
        logic tk;
        exp_t e, got;
        tk = clk25 && !rst;
        cyc++;
        if (rst) begin
            vis_cnt = 0;
            last_df = -1;
        end
        #1;
        if (tk) begin
            got = {disp, o_r, o_g, o_b, o_hs, o_vs, fin, fcnt};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underrun: got tick with no expected entry");
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL pixel_tick @cyc %0d: got vis=%b rgb=%b%b%b hs=%b vs=%b df=%b fc=%0d expected vis=%b rgb=%b%b%b hs=%b vs=%b df=%b fc=%0d",
                             cyc, got.vis, got.r, got.g, got.b, got.hs, got.vs, got.df, got.fc,
                             e.vis, e.r, e.g, e.b, e.hs, e.vs, e.df, e.fc);
                end
            end
            if (disp) vis_cnt++;
            if (fin) begin
                df_total++;
                chk("visible_ticks_per_frame", vis_cnt, HV * VV);
                if (last_df >= 0) chk("draw_finish_spacing_clk", cyc - last_df, FRAME_CLK);
                last_df = cyc;
                vis_cnt = 0;
            end
        end
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset("reset_init");
        @(negedge clk);
        rst = 1'b0;
        push_frames(3);
        repeat (2 * FRAME_CLK) @(negedge clk);
        // Abort the third frame in the middle of the visible area.
        n = 0;
        while (!(py == 10'd2 && px == 10'd5) && n < FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        chk("reach_abort_point", int'(n < FRAME_CLK), 1);
        q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        push_frames(2);
        repeat (2 * FRAME_CLK - 6) @(negedge clk);
        chk("draw_finish_total", df_total, 4);
        chk("frame_cnt_end", int'(fcnt), 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
